// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg
//   Shared defaults and helpers for the clock divider bank.
//   - NUM_CH_DEFAULT / CNT_W_DEFAULT / DEFAULT_DIV_DEFAULT : default parameters
//   - div_t       : divisor / counter word at the default width
//   - clkdiv_ch_w : width of the channel-select field, never less than 1
package clkdiv_pkg;

  localparam int NUM_CH_DEFAULT      = 7;
  localparam int CNT_W_DEFAULT       = 16;
  localparam int DEFAULT_DIV_DEFAULT = 25;

  typedef logic [CNT_W_DEFAULT-1:0] div_t;

  function automatic int clkdiv_ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// clkdiv_channel
//   One integer divider channel: active divisor, shadow divisor with a
//   pending flag, terminal-count down-counter, "seen" flag used by the
//   lock detector, and an optional toggle output.
//   Optional feature macro: CLKDIV_TOGGLE_OUT_EN (toggle flop on outclk).
// Ports
//   refclk   in  clock
//   rst      in  synchronous active-high reset
//   sync_in  in  realign: apply pending, reload counter, clear seen/toggle
//   wr_hit   in  write strobe already decoded for this channel
//   wr_div   in  divisor to capture into the shadow register
//   tick     out one-cycle pulse at terminal count
//   outclk   out toggle output (0 when the feature is compiled out)
//   pending  out shadow holds a write not yet applied
//   seen     out channel has ticked since reset / last sync
//   enabled  out active divisor is non-zero
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEFAULT
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             sync_in,
  input  logic             wr_hit,
  input  logic [CNT_W-1:0] wr_div,
  output logic             tick,
  output logic             outclk,
  output logic             pending,
  output logic             seen,
  output logic             enabled
);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] CNT_RST = (DEFAULT_DIV == 0) ? '0 : CNT_W'(DEFAULT_DIV - 1);

  // Counter reload for a divisor; a zero divisor parks the counter at 0.
  function automatic logic [CNT_W-1:0] reload_val(input logic [CNT_W-1:0] d);
    return (d == '0) ? '0 : d - ONE;
  endfunction

  logic [CNT_W-1:0] div_d, div_q;
  logic [CNT_W-1:0] shd_d, shd_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [CNT_W-1:0] new_div;
  logic             pend_d, pend_q;
  logic             seen_d, seen_q;
  logic             tick_int;

  // Reset gates the pulse so a DEFAULT_DIV of 1 cannot tick while in reset.
  assign tick_int = (cnt_q == '0) && (div_q != '0) && !sync_in && !rst;

  always_comb begin
    div_d   = div_q;
    shd_d   = shd_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    seen_d  = seen_q;
    new_div = pend_q ? shd_q : div_q;

    if (sync_in) begin
      div_d  = new_div;
      cnt_d  = reload_val(new_div);
      pend_d = 1'b0;
      seen_d = 1'b0;
    end else if (div_q == '0) begin
      // Disabled channel has no terminal count to wait for: apply at once.
      cnt_d = '0;
      if (pend_q) begin
        div_d  = shd_q;
        cnt_d  = reload_val(shd_q);
        pend_d = 1'b0;
      end
    end else if (tick_int) begin
      seen_d = 1'b1;
      div_d  = new_div;
      cnt_d  = reload_val(new_div);
      pend_d = 1'b0;
    end else begin
      cnt_d = cnt_q - ONE;
    end

    // A write in the same cycle lands after any apply, so it waits for the
    // following terminal count.
    if (wr_hit) begin
      shd_d  = wr_div;
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      div_q  <= DIV_RST;
      shd_q  <= DIV_RST;
      cnt_q  <= CNT_RST;
      pend_q <= 1'b0;
      seen_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      shd_q  <= shd_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      seen_q <= seen_d;
    end
  end

`ifdef CLKDIV_TOGGLE_OUT_EN
  logic tog_d, tog_q;

  always_comb begin
    tog_d = tog_q;
    if (sync_in) begin
      tog_d = 1'b0;
    end else if (tick_int) begin
      tog_d = ~tog_q;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      tog_q <= 1'b0;
    end else begin
      tog_q <= tog_d;
    end
  end

  assign outclk = tog_q;
`else
  assign outclk = 1'b0;
`endif

  assign tick    = tick_int;
  assign pending = pend_q;
  assign seen    = seen_q;
  assign enabled = (div_q != '0);

endmodule

// File: rtl/clock_divider_bank.sv
// clock_divider_bank
//   Bank of NUM_CH runtime-programmable integer dividers on refclk. Each
//   channel emits a one-cycle tick every D cycles (D=0 disables the channel);
//   divisor writes are shadowed and applied at the channel's terminal count.
//   Optional feature macro: CLKDIV_TOGGLE_OUT_EN (50 % duty toggle on outclk;
//   when undefined outclk is tied to 0).
// Ports
//   refclk   in  sole clock
//   rst      in  synchronous active-high reset
//   wr_en    in  divisor write strobe
//   wr_ch    in  target channel (out-of-range values are ignored)
//   wr_div   in  new divisor
//   sync_in  in  realign all channels
//   wr_busy  out per-channel unapplied-write flag
//   tick     out per-channel one-cycle period pulse
//   outclk   out per-channel toggle output
//   locked   out every enabled channel has ticked since reset / last sync
module clock_divider_bank
  import clkdiv_pkg::*;
#(
  parameter int  NUM_CH      = NUM_CH_DEFAULT,
  parameter int  CNT_W       = CNT_W_DEFAULT,
  parameter int  DEFAULT_DIV = DEFAULT_DIV_DEFAULT,
  localparam int CH_W        = clkdiv_ch_w(NUM_CH)
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_div,
  input  logic              sync_in,
  output logic [NUM_CH-1:0] wr_busy,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] outclk,
  output logic              locked
);

  logic [NUM_CH-1:0] wr_hit;
  logic [NUM_CH-1:0] seen;
  logic [NUM_CH-1:0] enabled;
  logic              locked_d, locked_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Channel indices at or above NUM_CH never match, so such writes drop.
    assign wr_hit[i] = wr_en && (wr_ch == CH_W'(i));

    clkdiv_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .refclk  (refclk),
      .rst     (rst),
      .sync_in (sync_in),
      .wr_hit  (wr_hit[i]),
      .wr_div  (wr_div),
      .tick    (tick[i]),
      .outclk  (outclk[i]),
      .pending (wr_busy[i]),
      .seen    (seen[i]),
      .enabled (enabled[i])
    );
  end

  // Including this cycle's tick makes locked rise the cycle right after the
  // last enabled channel's first tick rather than one cycle later.
  always_comb begin
    locked_d = 1'b0;
    if (!sync_in) begin
      locked_d = &(seen | tick | ~enabled);
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      locked_q <= 1'b0;
    end else begin
      locked_q <= locked_d;
    end
  end

  assign locked = locked_q;

endmodule

// File: tb/tb_clock_divider_bank.sv
module tb_clock_divider_bank;

  localparam int NUM_CH = 7;
  localparam int CNT_W  = 16;
  localparam int DEF    = 25;
`ifdef CLKDIV_TOGGLE_OUT_EN
  localparam bit TOG_EN = 1'b1;
`else
  localparam bit TOG_EN = 1'b0;
`endif

  logic              refclk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic [2:0]        wr_ch = '0;
  logic [CNT_W-1:0]  wr_div = '0;
  logic              sync_in = 1'b0;
  logic [NUM_CH-1:0] wr_busy, tick, outclk;
  logic              locked;

  clock_divider_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
    .refclk  (refclk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_ch   (wr_ch),
    .wr_div  (wr_div),
    .sync_in (sync_in),
    .wr_busy (wr_busy),
    .tick    (tick),
    .outclk  (outclk),
    .locked  (locked)
  );

  always #5 refclk = ~refclk;

  int checks = 0;
  int errors = 0;

  task automatic cmp(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: each channel is tracked as the absolute cycle number of
  // its next tick, plus its divisor and one-deep write queue.
  typedef struct {
    bit                chk;
    int                cyc;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] oclk;
    logic              locked;
  } exp_t;

  exp_t sb[$];

  int m_div  [NUM_CH];
  int m_shd  [NUM_CH];
  bit m_pend [NUM_CH];
  int m_next [NUM_CH];
  bit m_seen [NUM_CH];
  bit m_tog  [NUM_CH];
  bit m_locked;
  int cyc = 0;

  task automatic model_step(input bit r, input bit s, input bit we, input int ch, input int d);
    exp_t e;
    bit   all_ok;
    e.chk    = !r;
    e.cyc    = cyc;
    e.locked = m_locked;
    for (int i = 0; i < NUM_CH; i++) begin
      e.busy[i] = m_pend[i];
      e.oclk[i] = TOG_EN ? m_tog[i] : 1'b0;
      e.tick[i] = (m_div[i] != 0) && (m_next[i] == cyc) && !s;
    end
    sb.push_back(e);

    if (r) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_div[i] = DEF; m_shd[i] = DEF; m_pend[i] = 0;
        m_seen[i] = 0; m_tog[i] = 0; m_next[i] = cyc + DEF;
      end
      m_locked = 0;
    end else begin
      all_ok = 1;
      for (int i = 0; i < NUM_CH; i++)
        if (m_div[i] != 0 && !(m_seen[i] || e.tick[i])) all_ok = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (s) begin
          if (m_pend[i]) begin m_div[i] = m_shd[i]; m_pend[i] = 0; end
          m_next[i] = cyc + m_div[i];
          m_seen[i] = 0;
          m_tog[i]  = 0;
        end else if (m_div[i] == 0) begin
          if (m_pend[i]) begin
            m_div[i] = m_shd[i]; m_pend[i] = 0; m_next[i] = cyc + m_div[i];
          end
        end else if (e.tick[i]) begin
          m_seen[i] = 1;
          m_tog[i]  = !m_tog[i];
          if (m_pend[i]) begin m_div[i] = m_shd[i]; m_pend[i] = 0; end
          m_next[i] = cyc + m_div[i];
        end
        if (we && ch == i) begin m_shd[i] = d; m_pend[i] = 1; end
      end
      m_locked = !s && all_ok;
    end
    cyc++;
  endtask

  // Drive one cycle's inputs just after the rising edge and log the
  // expected response for that cycle.
  task automatic drive(input bit r, input bit s, input bit we, input int ch, input int d);
    @(posedge refclk);
    #1;
    rst = r; sync_in = s; wr_en = we; wr_ch = 3'(ch); wr_div = CNT_W'(d);
    model_step(r, s, we, ch, d);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0);
  endtask

  // Scoreboard monitor: samples on the falling edge, mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge refclk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk) begin
          cmp("tick",    e.cyc, 32'(tick),    32'(e.tick));
          cmp("wr_busy", e.cyc, 32'(wr_busy), 32'(e.busy));
          cmp("locked",  e.cyc, 32'(locked),  32'(e.locked));
          cmp("outclk",  e.cyc, 32'(outclk),  32'(e.oclk));
        end
      end
    end
  end

  initial begin
    bit r, s, we;
    int ch, d, sel;

    // reset, then directed default-rate phase with fixed-cycle landmarks
    for (int k = 0; k < 3; k++) drive(1, 0, 0, 0, 0);
    for (int k = 0; k < 80; k++) begin
      if (k == 10) drive(0, 0, 1, 3, 4);
      else         drive(0, 0, 0, 0, 0);
      #1;
      if (k == 0)  cmp("const_reset_busy",   k, 32'(wr_busy), 32'h0);
      if (k == 0)  cmp("const_reset_locked", k, 32'(locked),  32'h0);
      if (k == 11) cmp("const_busy3_rise",   k, 32'(wr_busy), 32'h08);
      if (k == 24) cmp("const_first_tick",   k, 32'(tick),    32'h7f);
      if (k == 24) cmp("const_busy3_last",   k, 32'(wr_busy), 32'h08);
      if (k == 25) cmp("const_busy3_fall",   k, 32'(wr_busy), 32'h00);
      if (k == 25) cmp("const_locked_rise",  k, 32'(locked),  32'h1);
      if (k == 28) cmp("const_ch3_tick28",   k, 32'(tick),    32'h08);
      if (k == 49) cmp("const_tick49",       k, 32'(tick),    32'h77);
    end

    // D=1 on ch0, D=0 on ch1
    drive(0, 0, 1, 0, 1);
    drive(0, 0, 1, 1, 0);
    idle(60);
    // realign, with and without a concurrent write
    drive(0, 1, 0, 0, 0);
    idle(40);
    drive(0, 1, 1, 6, 7);
    idle(40);
    // toggle output on ch2 with D=3; back-to-back overwrite on ch4
    drive(0, 0, 1, 2, 3);
    drive(0, 0, 1, 4, 5);
    drive(0, 0, 1, 4, 6);
    idle(50);
    // pending write discarded by reset
    drive(0, 0, 1, 5, 9);
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    idle(40);
    // out-of-range channel
    drive(0, 0, 1, 7, 2);
    idle(30);
    // re-enable a disabled channel
    drive(0, 0, 1, 1, 2);
    idle(20);

    // randomized traffic with small divisors so ticks are frequent
    for (int k = 0; k < 4000; k++) begin
      r   = ($urandom_range(0, 999) == 0);
      s   = ($urandom_range(0, 149) == 0);
      we  = ($urandom_range(0, 5) == 0);
      ch  = $urandom_range(0, 7);
      sel = $urandom_range(0, 9);
      d   = (sel < 3) ? sel : $urandom_range(2, 13);
      drive(r, s, we, ch, d);
    end
    idle(5);

    @(negedge refclk);
    @(negedge refclk);
    cmp("scoreboard_drained", cyc, 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_divider_bank.md
# clock_divider_bank

Parametrised, runtime-programmable bank of NUM_CH integer clock dividers running entirely in the `refclk` domain. Each channel produces a single-cycle `tick` clock-enable every D reference cycles, plus an optional 50 % duty toggled output. Divisors change glitch-free at each channel's terminal count. The block sits beside the fixed PLL divider and serves the low-rate, software-adjustable rates the PLL cannot synthesise. Downstream logic stays on `refclk` and qualifies its work with `tick`.

## Interface
- NUM_CH, 7, number of divider channels (1..32)
- CNT_W, 16, divisor and counter width
- DEFAULT_DIV, 25, divisor loaded into every channel at reset (must be < 2^CNT_W)
- refclk  in  1  sole clock; all flops on its rising edge
- rst  in  1  reset, synchronous, active-high; overrides every other input
- wr_en  in  1  divisor write strobe, single cycle
- wr_ch  in  CH_W = max(1, $clog2(NUM_CH))  target channel
- wr_div  in  CNT_W  new divisor D
- sync_in  in  1  realign all channels
- wr_busy  out  NUM_CH  a channel's bit is high while that channel has an unapplied write
- tick  out  NUM_CH  one-cycle pulse per channel period
- outclk  out  NUM_CH  toggle outputs (see Configuration)
- locked  out  1  every enabled channel has ticked since the last reset or sync

## Operation
- Per channel: active divisor `div`, shadow divisor `shd`, pending bit, down-counter `cnt`.
- Divisor semantics:
  - D = 0: channel disabled. `cnt` is held at 0, `tick` stays 0, and the channel is excluded from `locked`.
  - D = 1: `tick` is high every cycle.
  - D ≥ 2: `tick` pulses once every D cycles.
- Counting: `tick[i]` = (`cnt` == 0) && (`div` != 0) && !`sync_in`. On a tick, `cnt` reloads `div`-1; otherwise it decrements.
- Writes:
  - When `wr_en` is high and `wr_ch` < NUM_CH, `shd` ← `wr_div` and pending ← 1.
  - When `wr_ch` ≥ NUM_CH, the write is ignored.
  - A write to a channel whose pending bit is already set overwrites `shd`; the last write wins.
- Apply: at a cycle where the channel ticks and the pending bit is set (as it stood at the start of that cycle):
  - `div` ← `shd`;
  - `cnt` ← `shd`-1, or 0 if `shd` = 0;
  - pending ← 0.
- A disabled channel (`div` = 0) with pending set applies its write on the following cycle.
- Write in a terminal cycle: the reload in that cycle uses the pre-write state, so the new value applies at the channel's next terminal count.
- `sync_in`:
  - Every channel applies any pending `shd`, then loads `cnt` ← `div`-1.
  - `outclk` clears to 0, `locked` clears to 0, and all ticks are suppressed in that cycle.
  - A `wr_en` in the same cycle is still captured into `shd` and set pending; it is applied at a later terminal count.
- `locked`: a per-channel `seen` bit sets on that channel's tick. `locked` is registered as AND over enabled channels of `seen`. If all channels are disabled, `locked` goes high one cycle after reset.

## Timing
- Reset values:
  - `div` = `shd` = DEFAULT_DIV, `cnt` = DEFAULT_DIV-1;
  - pending, `wr_busy`, `tick`, `outclk`, `locked`, `seen` all 0.
- Cycle numbering: cycle 0 is the first cycle with `rst` low. The first tick of a channel with divisor D is in cycle D-1, and repeats every D cycles after that.
- `wr_busy` rises the cycle after `wr_en` and falls the cycle after the apply.
- `locked` rises one cycle after the last enabled channel's first tick.
- `rst` asserted mid-operation discards pending writes and returns every channel to its reset values at the next edge.

## Configuration
- CLKDIV_TOGGLE_OUT_EN defined: `outclk[i]` is a flop that toggles on every `tick[i]`, giving period 2D with 50 % duty; it is cleared by `rst` and by `sync_in`.
- CLKDIV_TOGGLE_OUT_EN undefined: the `outclk` port remains, is tied to 0, and no toggle flops are inferred.

## Structure
- Package `clkdiv_pkg` holds the defaults for NUM_CH, CNT_W and DEFAULT_DIV, the typedef `div_t` (logic [CNT_W-1:0]) and the function computing CH_W.
- Sub-module `clkdiv_channel` contains the counter, shadow register, pending bit, `seen` bit and toggle flop for one channel. The top generates NUM_CH instances of it, plus the write decode and the `locked` reduction.

## Test plan
- Reset release with defaults (NUM_CH=7, DEFAULT_DIV=25) -> all ticks in cycles 24, 49, 74; `locked` rises in cycle 25; `wr_busy` stays 0.
- Write ch3 D=4 in cycle 10 -> `wr_busy[3]` high cycles 11..24; apply at cycle 24; ch3 ticks at 28, 32, 36; other channels stay at 49, 74.
- Write D=1 to ch0 and D=0 to ch1 -> ch0 ticks every cycle after its apply; ch1 tick stays 0 and `locked` stays high.
- `sync_in` in cycle 100 with all D=25 -> no tick in cycle 100; `locked` 0 in cycle 101; next ticks in cycle 125; `locked` high again in cycle 126.
- Macro defined, ch2 D=3 -> `outclk[2]` has a 6-cycle period, high 3 cycles; macro undefined -> `outclk` constant 0.
- `rst` pulse while ch5 has a pending D=9 -> pending discarded; ch5 ticks 25 cycles after reset release; `wr_busy[5]` is 0.
